// File: rtl/byte_demux_1_to_4.sv
// byte_demux_1_to_4
// Registered 1-to-4 byte demultiplexer. One incoming byte is steered by
// {s1,s0} into one of four single-entry lane holding registers. Each lane
// hands its byte to a downstream consumer under a valid/ack handshake. A lane
// never overwrites a byte that has not been consumed. Instead, back-pressure
// reaches the producer through i_ready.
module byte_demux_1_to_4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i,
    input  logic       s0,
    input  logic       s1,
    input  logic       i_valid,
    output logic       i_ready,
    output logic [7:0] o0,
    output logic [7:0] o1,
    output logic [7:0] o2,
    output logic [7:0] o3,
    output logic       v0,
    output logic       v1,
    output logic       v2,
    output logic       v3,
    input  logic       a0,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    output logic [2:0] full_cnt
);

    localparam int DATA_W = 8;
    localparam int LANES  = 4;

    // Lane state: one holding register and one full flag per lane.
    logic [DATA_W-1:0] lane_data_p0 [LANES];
    logic [LANES-1:0]  lane_vld_p0;
    logic [2:0]        full_cnt_p0;

    logic [1:0]        sel;
    logic [LANES-1:0]  ack_vec;
    logic [LANES-1:0]  consume_vec;
    logic [LANES-1:0]  wr_vec;
    logic [LANES-1:0]  vld_nxt;
    logic              acc;
    logic              fill_empty;
    logic [2:0]        drain_cnt;
    logic [2:0]        cnt_nxt;

    // Count the set bits of a 4-bit lane mask. The result is 0..4.
    function automatic logic [2:0] popcount4(input logic [LANES-1:0] x);
        logic [2:0] sum;
        sum = 3'd0;
        for (int k = 0; k < LANES; k++) begin
            sum = sum + {2'b00, x[k]};
        end
        return sum;
    endfunction

    // Handshake decode. i_ready depends only on the selected lane's state and
    // ack, and never on i or i_valid, so no combinational loop can form
    // through the producer.
    always_comb begin
        sel         = {s1, s0};
        ack_vec     = {a3, a2, a1, a0};
        i_ready     = ~lane_vld_p0[sel] | ack_vec[sel];
        acc         = i_valid & i_ready;
        wr_vec      = '0;
        if (acc) begin
            wr_vec[sel] = 1'b1;
        end
        // Acks on empty lanes are ignored.
        consume_vec = ack_vec & lane_vld_p0;
        vld_nxt     = (lane_vld_p0 & ~consume_vec) | wr_vec;
        // A lane that is acked and refilled in the same cycle neither adds
        // to nor subtracts from the occupancy count.
        fill_empty  = acc & ~lane_vld_p0[sel];
        drain_cnt   = popcount4(consume_vec & ~wr_vec);
        cnt_nxt     = full_cnt_p0 + {2'b00, fill_empty} - drain_cnt;
    end

    // Lane full flags and occupancy count. Reset discards any pending bytes
    // without requiring an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_vld_p0 <= '0;
            full_cnt_p0 <= 3'd0;
        end else begin
            lane_vld_p0 <= vld_nxt;
            full_cnt_p0 <= cnt_nxt;
        end
    end

    // Lane holding registers. Only the accepted lane is written. A drained
    // lane keeps its last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < LANES; n++) begin
                lane_data_p0[n] <= '0;
            end
        end else begin
            for (int n = 0; n < LANES; n++) begin
                if (wr_vec[n]) begin
                    lane_data_p0[n] <= i;
                end
            end
        end
    end

    assign o0       = lane_data_p0[0];
    assign o1       = lane_data_p0[1];
    assign o2       = lane_data_p0[2];
    assign o3       = lane_data_p0[3];
    assign v0       = lane_vld_p0[0];
    assign v1       = lane_vld_p0[1];
    assign v2       = lane_vld_p0[2];
    assign v3       = lane_vld_p0[3];
    assign full_cnt = full_cnt_p0;

endmodule

// File: tb/tb_byte_demux_1_to_4.sv
// Testbench for byte_demux_1_to_4: directed vector table, hand-written
// reset and streaming sequences, and randomized traffic against a
// lane-occupancy reference model.
module tb_byte_demux_1_to_4;

    logic       clk;
    logic       rst_n;
    logic [7:0] i;
    logic       s0, s1, i_valid, i_ready;
    logic [7:0] o0, o1, o2, o3;
    logic       v0, v1, v2, v3;
    logic       a0, a1, a2, a3;
    logic [2:0] full_cnt;

    int n_vec;
    int n_bad;

    // Reference model: what each lane holds and whether it is occupied.
    logic [7:0] m_byte [4];
    bit         m_full [4];

    typedef struct {
        logic [7:0]  i;
        logic [1:0]  sel;
        logic        vld;
        logic [3:0]  a;
        logic        exp_rdy;
        logic [3:0]  exp_v;
        logic [31:0] exp_o;   // {o3,o2,o1,o0}
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t tbl [15];

    byte_demux_1_to_4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i        (i),
        .s0       (s0),
        .s1       (s1),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .v0       (v0),
        .v1       (v1),
        .v2       (v2),
        .v3       (v3),
        .a0       (a0),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .full_cnt (full_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, n_vec, got, exp);
        end
    endtask

    task automatic check_outputs(input logic [3:0] ev, input logic [31:0] eo, input logic [2:0] ec);
        check("v", {28'd0, v3, v2, v1, v0}, {28'd0, ev});
        check("o", {o3, o2, o1, o0}, eo);
        check("full_cnt", {29'd0, full_cnt}, {29'd0, ec});
    endtask

    // Drive one cycle of stimulus. The caller is 1 time unit past a rising
    // edge. i_ready is checked mid-cycle, and the lane outputs are checked
    // just after the next edge.
    task automatic apply(input logic [7:0] din, input logic [1:0] sel, input logic vld,
                         input logic [3:0] a, input logic exp_rdy, input logic [3:0] exp_v,
                         input logic [31:0] exp_o, input logic [2:0] exp_cnt);
        n_vec++;
        i       = din;
        {s1, s0} = sel;
        i_valid = vld;
        {a3, a2, a1, a0} = a;
        #1;
        check("i_ready", {31'd0, i_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        #1;
        check_outputs(exp_v, exp_o, exp_cnt);
    endtask

    task automatic idle_inputs();
        i = 8'h00; s0 = 1'b0; s1 = 1'b0; i_valid = 1'b0;
        {a3, a2, a1, a0} = 4'b0000;
    endtask

    // One random cycle, with expectations taken from the lane model.
    task automatic random_cycle();
        logic [7:0]  din;
        logic [1:0]  sel;
        logic        vld;
        logic [3:0]  a;
        logic        rdy;
        logic [3:0]  ev;
        logic [31:0] eo;
        int          cnt;
        din = 8'($urandom);
        sel = 2'($urandom_range(0, 3));
        vld = ($urandom_range(0, 3) != 0);
        for (int n = 0; n < 4; n++) a[n] = ($urandom_range(0, 9) < 4);
        rdy = !m_full[sel] || a[sel];
        for (int n = 0; n < 4; n++) begin
            if (n == int'(sel) && vld && rdy) begin
                m_full[n] = 1'b1;
                m_byte[n] = din;
            end else if (a[n] && m_full[n]) begin
                m_full[n] = 1'b0;
            end
        end
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            ev[n] = m_full[n];
            eo[n*8 +: 8] = m_byte[n];
            if (m_full[n]) cnt++;
        end
        apply(din, sel, vld, a, rdy, ev, eo, 3'(cnt));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle_inputs();
        rst_n = 1'b0;

        // Directed table, starting from a freshly reset block.
        tbl[0]  = '{8'hFF, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'h000000FF, 3'd1};
        tbl[1]  = '{8'h00, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 32'h000000FF, 3'd2};
        tbl[2]  = '{8'hAA, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 32'h00AA00FF, 3'd3};
        tbl[3]  = '{8'h0F, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 32'h0FAA00FF, 3'd4};
        tbl[4]  = '{8'h55, 2'd2, 1'b1, 4'b0000, 1'b0, 4'b1111, 32'h0FAA00FF, 3'd4};
        tbl[5]  = '{8'h3C, 2'd1, 1'b1, 4'b0010, 1'b1, 4'b1111, 32'h0FAA3CFF, 3'd4};
        tbl[6]  = '{8'h77, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0FAA3CFF, 3'd0};
        tbl[7]  = '{8'h99, 2'd2, 1'b0, 4'b0100, 1'b1, 4'b0000, 32'h0FAA3CFF, 3'd0};
        tbl[8]  = '{8'h12, 2'd1, 1'b0, 4'b0000, 1'b1, 4'b0000, 32'h0FAA3CFF, 3'd0};
        tbl[9]  = '{8'h34, 2'd3, 1'b0, 4'b0000, 1'b1, 4'b0000, 32'h0FAA3CFF, 3'd0};
        tbl[10] = '{8'h56, 2'd0, 1'b0, 4'b0000, 1'b1, 4'b0000, 32'h0FAA3CFF, 3'd0};
        tbl[11] = '{8'h11, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'h0FAA3C11, 3'd1};
        tbl[12] = '{8'h22, 2'd1, 1'b1, 4'b0001, 1'b1, 4'b0010, 32'h0FAA2211, 3'd1};
        tbl[13] = '{8'h33, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0010, 32'h0FAA2211, 3'd1};
        tbl[14] = '{8'h44, 2'd0, 1'b0, 4'b0010, 1'b1, 4'b0000, 32'h0FAA2211, 3'd0};

        // Power-up reset values.
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        check_outputs(4'b0000, 32'h0, 3'd0);
        check("i_ready_reset", {31'd0, i_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 15; t++) begin
            apply(tbl[t].i, tbl[t].sel, tbl[t].vld, tbl[t].a, tbl[t].exp_rdy,
                  tbl[t].exp_v, tbl[t].exp_o, tbl[t].exp_cnt);
        end

        // Streaming into lane 3 with the consumer acking every cycle.
        for (int b = 1; b <= 8; b++) begin
            apply(8'(b), 2'd3, 1'b1, 4'b1000, 1'b1, 4'b1000,
                  {8'(b), 24'hAA2211}, 3'd1);
        end
        apply(8'h00, 2'd3, 1'b0, 4'b1000, 1'b1, 4'b0000, 32'h08AA2211, 3'd0);

        // Asynchronous reset mid-cycle while all lanes are full.
        apply(8'hA0, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'h08AA22A0, 3'd1);
        apply(8'hA1, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 32'h08AAA1A0, 3'd2);
        apply(8'hA2, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 32'h08A2A1A0, 3'd3);
        apply(8'hA3, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 32'hA3A2A1A0, 3'd4);
        idle_inputs();
        i_valid = 1'b1;
        {s1, s0} = 2'd2;
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        check_outputs(4'b0000, 32'h0, 3'd0);
        check("i_ready_async_reset", {31'd0, i_ready}, 32'd1);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // After release the block behaves as from power-up.
        apply(8'h5A, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 32'h005A0000, 3'd1);

        // Randomized traffic checked against the lane model.
        for (int n = 0; n < 4; n++) begin
            m_full[n] = 1'b0;
            m_byte[n] = 8'h00;
        end
        m_full[2] = 1'b1;
        m_byte[2] = 8'h5A;
        for (int c = 0; c < 400; c++) begin
            random_cycle();
        end

        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_demux_1_to_4.md
# byte_demux_1_to_4

Registered 1-to-4 byte demultiplexer: the write-side counterpart of the processor's 4-to-1 byte mux. It steers one incoming byte, selected by `s1:s0`, into one of four single-entry lane holding registers. Each lane presents its byte to a downstream consumer (register-file bank or pipeline-stage latch) under a valid/ack handshake. A lane never drops or overwrites an unconsumed byte; back-pressure goes to the producer through `i_ready`.

## Interface
Parameters:
- none; the data width is fixed at 8 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i`  in  8  input byte.
- `s0`  in  1  lane select, LSB.
- `s1`  in  1  lane select, MSB; lane index = {s1,s0}.
- `i_valid`  in  1  producer has a byte on `i` for the lane `{s1,s0}`.
- `i_ready`  out  1  selected lane can accept this cycle (combinational).
- `o0`, `o1`, `o2`, `o3`  out  8 each  lane holding registers.
- `v0`, `v1`, `v2`, `v3`  out  1 each  lane full / byte valid.
- `a0`, `a1`, `a2`, `a3`  in  1 each  consumer ack; consumes the lane byte when `vN=1`.
- `full_cnt`  out  3  number of lanes currently full, 0..4.

## Operation
- Lane N has two states, EMPTY (`vN=0`) and FULL (`vN=1`).
- Accept: `acc = i_valid & i_ready`.
- `i_ready = ~v[sel] | a[sel]`, where sel = {s1,s0}. A full lane being acked in the same cycle can accept a new byte.
- On `acc`, lane sel transitions as follows:
  - EMPTY→FULL, or FULL→FULL when acked the same cycle.
  - `o[sel] <= i`.
- On `aN & vN` with no accept to lane N: FULL→EMPTY.
  - `oN` keeps its last value; it is not cleared.
- `aN` while `vN=0` is ignored and causes no state change.
- Unselected lanes are never written, regardless of `i_valid`.
- `i_valid=0`: no lane is written. `i_ready` still reflects the selected lane.
- `full_cnt` is registered and equals the popcount of v0..v3 after each edge.
  - Update rule: `+1` for an accept into an EMPTY lane, `-1` for each ack on a FULL lane not refilled the same cycle.
  - Several acks in one cycle are summed.
  - Never exceeds 4 and never underflows.
- The select inputs `s1:s0` and `i` only need to be stable around the clock edge. `s0`/`s1` may change every cycle.

## Timing
- Reset (`rst_n=0`, asynchronous, effective immediately, independent of `clk`):
  - `o0..o3 = 8'h00`, `v0..v3 = 0`, `full_cnt = 0`.
  - `i_ready` is then 1 for any select.
- Reset release: the first accept can occur on the first rising edge with `rst_n=1`.
- Reset asserted mid-handshake: all pending bytes are discarded with no ack required. After release, behaviour is as from power-up.
- Latency: a byte accepted at edge k appears on `o[sel]` with `v[sel]=1` immediately after edge k (1 cycle).
- Throughput, one lane: 1 byte/cycle when the consumer acks every cycle. Otherwise 1 byte per ack.
- Throughput, rotating select: 1 byte/cycle across lanes, up to 4 outstanding.
- `i_ready` is purely combinational from `v[sel]`, `a[sel]`, `s0` and `s1`. There is no combinational path from `i` or `i_valid` to `i_ready`.
- Simultaneous accept and ack on the same lane: the new byte replaces the old one, `vN` stays 1, and `full_cnt` is unchanged.
- Simultaneous accept on lane X and ack on lane Y≠X: both take effect, and `full_cnt` is unchanged.

## Test plan
- **Reset values:** assert `rst_n=0` mid-cycle with lanes full → all `o`, `v` and `full_cnt` go to 0 immediately, without a clock edge. `i_ready=1`.
- **Directed fill:** with no acks, write `8'hFF`, `8'h00`, `8'hAA`, `8'h0F` to sel 0, 1, 2, 3 on consecutive cycles.
  - Expect `o0..o3 = FF/00/AA/0F`, `v=4'b1111`, `full_cnt=4`.
  - Then `i_valid=1`, sel=2, `i=8'h55` → `i_ready=0` and `o2` stays `8'hAA`.
- **Ack and refill in the same cycle:** lane 1 full with `8'h00`; drive `a1=1`, `i_valid=1`, sel=1, `i=8'h3C`.
  - Expect `i_ready=1`, `o1=8'h3C` after the edge, `v1=1`, `full_cnt` unchanged.
- **Drain:** all lanes full, assert `a0..a3=1` together for one cycle → `v=0`, `full_cnt` goes 4→0 in one edge, and the `o` values are retained.
- **Stray ack / idle:** `a2=1` on an empty lane, and `i_valid=0` with sel toggling every cycle → no `v` or `o` change, `full_cnt=0`.
- **Streaming:** sel fixed at 3, `a3` held high, 8 consecutive bytes `8'h01`..`8'h08` → `i_ready=1` every cycle and `o3` tracks each byte one cycle later. `full_cnt=1` from the first accept until the stream ends, then 0 one edge after the last ack.
